// File: rtl/aula_201029_qsys_nios2_qsys_rc_ocimem_master.sv
// Sysclk-side OCI memory master: decodes debugger jdo commands into single-word
// Avalon-MM reads/writes and reports the result through MonDReg/monitor_* flags.
module aula_201029_qsys_nios2_qsys_rc_ocimem_master #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W+1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam int unsigned CNT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [31:0] ABORT_PAT = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              autoinc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              rd_q;
  logic              wr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mon_q;
  logic              ready_q;
  logic              err_q;

  logic busy_c;
  logic win_a_c;
  logic win_b_c;
  logic win_na_c;
  logic multi_c;
  logic drop_c;
  logic start_c;
  logic tmo_c;

  // jdo bits that carry no command field
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  // Strobe arbitration (A > B > no_action_a), drop and watchdog detection
  always_comb begin
    busy_c   = (state_q != ST_IDLE);
    win_a_c  = take_action_ocimem_a;
    win_b_c  = take_action_ocimem_b & ~take_action_ocimem_a;
    win_na_c = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
    multi_c  = (take_action_ocimem_a & take_action_ocimem_b) |
               (take_action_ocimem_a & take_no_action_ocimem_a) |
               (take_action_ocimem_b & take_no_action_ocimem_a);
    drop_c   = busy_c ? (take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a)
                      : multi_c;
    start_c  = ~busy_c & ((win_a_c & jdo[35]) | win_b_c | win_na_c);
    tmo_c    = busy_c & avm_waitrequest & (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  // Command FSM with registered bus and monitor outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      autoinc_q <= 1'b0;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      mon_q     <= '0;
      ready_q   <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      // ready drops with an accepted transfer and returns one cycle after IDLE
      if (start_c) begin
        ready_q <= 1'b0;
      end else if (!busy_c) begin
        ready_q <= 1'b1;
      end

      // a drop in the same cycle as an accepted transfer still flags the error
      if (drop_c || tmo_c) begin
        err_q <= 1'b1;
      end else if (start_c) begin
        err_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (win_a_c) begin
            addr_q    <= jdo[ADDR_W+16:17];
            autoinc_q <= jdo[34];
            if (jdo[35]) begin
              state_q <= ST_READ;
              rd_q    <= 1'b1;
              cnt_q   <= '0;
            end
          end else if (win_b_c) begin
            wdata_q <= jdo[34:3];
            mon_q   <= jdo[34:3];
            state_q <= ST_WRITE;
            wr_q    <= 1'b1;
            cnt_q   <= '0;
          end else if (win_na_c) begin
            if (autoinc_q) begin
              addr_q <= addr_q + ADDR_W'(1);
            end
            state_q <= ST_READ;
            rd_q    <= 1'b1;
            cnt_q   <= '0;
          end
        end

        ST_READ, ST_WRITE: begin
          if (!avm_waitrequest) begin
            if (state_q == ST_READ) begin
              mon_q <= avm_readdata;
            end else if (autoinc_q) begin
              addr_q <= addr_q + ADDR_W'(1);
            end
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            state_q <= ST_IDLE;
          end else if (tmo_c) begin
            mon_q   <= ABORT_PAT;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= ST_IDLE;
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
        end
      endcase
    end
  end

  assign avm_address   = {addr_q, 2'b00};
  assign avm_read      = rd_q;
  assign avm_write     = wr_q;
  assign avm_writedata = wdata_q;
  assign MonDReg       = mon_q;
  assign monitor_ready = ready_q;
  assign monitor_error = err_q;

endmodule

// File: tb/tb_aula_201029_qsys_nios2_qsys_rc_ocimem_master.sv
// Scoreboard bench for the OCI memory master: a command-level model predicts bus
// beats and monitor results; independent monitors compare them as the DUT emits.
module tb_aula_201029_qsys_nios2_qsys_rc_ocimem_master;

  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [37:0]       jdo = '0;
  logic              take_action_ocimem_a = 1'b0;
  logic              take_action_ocimem_b = 1'b0;
  logic              take_no_action_ocimem_a = 1'b0;
  logic [ADDR_W+1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic              avm_waitrequest = 1'b0;
  logic [31:0]       avm_readdata = '0;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;

  aula_201029_qsys_nios2_qsys_rc_ocimem_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .avm_address             (avm_address),
    .avm_read                (avm_read),
    .avm_write               (avm_write),
    .avm_writedata           (avm_writedata),
    .avm_waitrequest         (avm_waitrequest),
    .avm_readdata            (avm_readdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  // kind: 0 read beat, 1 write beat, 2 watchdog abort, 3 reset abort
  typedef struct packed {
    logic [1:0]        kind;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [15:0]       cycles;
  } bus_t;

  typedef struct packed {
    logic [31:0]       mon;
    logic              err;
    logic [ADDR_W-1:0] addr;
  } res_t;

  bus_t bus_q[$];
  res_t res_q[$];

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  int checks = 0;
  int errors = 0;
  int stall_n = 0;

  // Command-level reference state
  logic [ADDR_W-1:0] m_addr = '0;
  logic              m_ai = 1'b0;
  logic              m_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave: stalls stall_n cycles per request, returns memory contents
  int req_cycles = 0;
  always @(posedge clk) begin
    #1;
    if (avm_read || avm_write) begin
      avm_waitrequest = (req_cycles < stall_n);
      avm_readdata    = mem[avm_address[ADDR_W+1:2]];
      req_cycles++;
    end else begin
      req_cycles      = 0;
      avm_waitrequest = 1'b0;
      avm_readdata    = $urandom;
    end
  end

  // Monitors: bus beats/aborts and monitor_ready rising edges
  int   req_cyc = 0;
  bit   prev_req = 1'b0;
  bit   prev_wait = 1'b0;
  bit   prev_rdy = 1'b1;
  bus_t be;
  res_t re;
  always @(negedge clk) begin
    if (avm_read || avm_write) begin
      req_cyc++;
      if (!avm_waitrequest) begin
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got addr %0h expected no beat", avm_address);
        end else begin
          be = bus_q.pop_front();
          chk("beat_kind", 64'(avm_write), 64'(be.kind));
          chk("beat_addr", 64'(avm_address), 64'({be.addr, 2'b00}));
          if (avm_write) chk("beat_wdata", 64'(avm_writedata), 64'(be.wdata));
          chk("beat_cycles", 64'(req_cyc), 64'(be.cycles));
          chk("rd_wr_excl", 64'(avm_read & avm_write), 64'(0));
        end
        req_cyc = 0;
      end
    end else begin
      if (prev_req && prev_wait) begin
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_abort: got abort expected no abort");
        end else begin
          be = bus_q.pop_front();
          chk("abort_kind", reset_n ? 64'd2 : 64'd3, 64'(be.kind));
          if (be.kind == 2'd2) chk("abort_cycles", 64'(req_cyc), 64'(be.cycles));
        end
      end
      req_cyc = 0;
    end
    prev_req  = avm_read | avm_write;
    prev_wait = avm_waitrequest;

    if (monitor_ready && !prev_rdy) begin
      if (res_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: got MonDReg %0h expected none", MonDReg);
      end else begin
        re = res_q.pop_front();
        chk("res_mondreg", 64'(MonDReg), 64'(re.mon));
        chk("res_error", 64'(monitor_error), 64'(re.err));
        chk("res_addr", 64'(avm_address), 64'({re.addr, 2'b00}));
      end
    end
    prev_rdy = monitor_ready;
  end

  task automatic wait_ready();
    int n = 0;
    while (!monitor_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!monitor_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got ready 0 expected 1");
    end
  endtask

  // Issue one strobe set; model predicts the resulting beat and result
  task automatic do_cmd(input bit a, input bit b, input bit na,
                        input logic [ADDR_W-1:0] addr, input bit rd, input bit ai,
                        input logic [31:0] wd, input int stall, input bit during);
    bit          drop, xfer, is_wr, tmo;
    logic [37:0] j;
    bus_t        eb;
    res_t        er;
    logic [31:0] mon;
    drop  = (int'(a) + int'(b) + int'(na)) > 1;
    xfer  = 1'b0;
    is_wr = 1'b0;
    tmo   = (stall >= int'(TIMEOUT));
    if (a) begin
      m_addr = addr; m_ai = ai; xfer = rd;
    end else if (b) begin
      xfer = 1'b1; is_wr = 1'b1;
    end else if (na) begin
      if (m_ai) m_addr = m_addr + 1'b1;
      xfer = 1'b1;
    end
    if (xfer) begin
      eb.kind   = tmo ? 2'd2 : (is_wr ? 2'd1 : 2'd0);
      eb.addr   = m_addr;
      eb.wdata  = wd;
      eb.cycles = tmo ? 16'(TIMEOUT) : 16'(stall + 1);
      bus_q.push_back(eb);
      mon = tmo ? 32'hDEADBEEF : (is_wr ? wd : mem[m_addr]);
      if (is_wr && !tmo) begin
        mem[m_addr] = wd;
        if (m_ai) m_addr = m_addr + 1'b1;
      end
      m_err = drop | during | tmo;
      er.mon = mon; er.err = m_err; er.addr = m_addr;
      res_q.push_back(er);
    end else begin
      m_err = m_err | drop;
    end

    stall_n = stall;
    j[37:32] = 6'($urandom);
    j[31:0]  = $urandom;
    if (a) begin
      j[ADDR_W+16:17] = addr; j[35] = rd; j[34] = ai;
    end else if (b) begin
      j[34:3] = wd;
    end
    @(negedge clk);
    jdo = j;
    take_action_ocimem_a = a; take_action_ocimem_b = b; take_no_action_ocimem_a = na;
    @(negedge clk);
    take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
    if (during) begin
      jdo = {6'($urandom), $urandom};
      take_action_ocimem_b = 1'b1;
      @(negedge clk);
      take_action_ocimem_b = 1'b0;
    end
    if (xfer) wait_ready();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    bus_t eb;
    res_t er;
    int   op;
    bit   collide, dur;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;

    #1 reset_n = 1'b0;
    #2;
    chk("rst_ready", 64'(monitor_ready), 64'(1));
    chk("rst_error", 64'(monitor_error), 64'(0));
    chk("rst_mondreg", 64'(MonDReg), 64'(0));
    chk("rst_req", 64'({avm_read, avm_write}), 64'(0));
    chk("rst_addr", 64'(avm_address), 64'(0));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // zero-wait read
    mem[5] = 32'h12345678;
    do_cmd(1, 0, 0, 9'h005, 1, 0, 32'h0, 0, 0);
    // address load, then stalled write with auto-increment
    do_cmd(1, 0, 0, 9'h010, 0, 1, 32'h0, 0, 0);
    do_cmd(0, 1, 0, 9'h000, 0, 0, 32'hCAFEF00D, 3, 0);
    // watchdog abort, then a good read clears the error
    do_cmd(1, 0, 0, 9'h020, 1, 0, 32'h0, 100000, 0);
    do_cmd(1, 0, 0, 9'h021, 1, 0, 32'h0, 1, 0);
    // address wrap on auto-increment
    do_cmd(1, 0, 0, 9'h1FF, 0, 1, 32'h0, 0, 0);
    do_cmd(0, 0, 1, 9'h000, 0, 0, 32'h0, 0, 0);
    // collision A+B, then strobe during a stalled read
    do_cmd(1, 1, 0, 9'h040, 1, 0, 32'h0, 1, 0);
    do_cmd(1, 0, 0, 9'h041, 1, 0, 32'h0, 3, 1);

    // randomized command mix
    for (int i = 0; i < 40; i++) begin
      op      = $urandom_range(0, 3);
      collide = ($urandom_range(0, 5) == 0);
      dur     = ($urandom_range(0, 7) == 0);
      case (op)
        0: do_cmd(1, collide, collide & 1'($urandom), 9'($urandom), 1, 1'($urandom),
                  32'h0, $urandom_range(0, 4), dur);
        1: do_cmd(1, 0, 0, 9'($urandom), 0, 1'($urandom), 32'h0, 0, 0);
        2: do_cmd(0, 1, collide, 9'h0, 0, 0, $urandom, $urandom_range(0, 4), dur);
        default: do_cmd(0, 0, 1, 9'h0, 0, 0, 32'h0, $urandom_range(0, 4), dur);
      endcase
    end

    // reset in the middle of a stalled read
    eb.kind = 2'd3; eb.addr = '0; eb.wdata = '0; eb.cycles = '0;
    bus_q.push_back(eb);
    er.mon = '0; er.err = 1'b0; er.addr = '0;
    res_q.push_back(er);
    stall_n = 100000;
    @(negedge clk);
    jdo = '0; jdo[ADDR_W+16:17] = 9'h033; jdo[35] = 1'b1;
    take_action_ocimem_a = 1'b1;
    @(negedge clk);
    take_action_ocimem_a = 1'b0;
    repeat (10) @(negedge clk);
    chk("stall_read_active", 64'(avm_read), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("arst_read", 64'(avm_read), 64'(0));
    chk("arst_ready", 64'(monitor_ready), 64'(1));
    chk("arst_mondreg", 64'(MonDReg), 64'(0));
    chk("arst_addr", 64'(avm_address), 64'(0));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    m_addr = '0; m_ai = 1'b0; m_err = 1'b0;
    stall_n = 0;
    do_cmd(1, 0, 0, 9'h007, 1, 0, 32'h0, 0, 0);

    repeat (5) @(negedge clk);
    chk("bus_q_drained", 64'(bus_q.size()), 64'(0));
    chk("res_q_drained", 64'(res_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
